// File: rtl/adc_serial_emulator_if.sv
// Serial ADC link plus parallel sample port between a sample source and the emulator.
// slave = emulator side; master = controller/stimulus side.
interface adc_serial_emulator_if #(
  parameter int DATA_BITS = 12
);
  logic                 sclk;
  logic                 cs_n;
  logic                 sdata;
  logic                 sdata_oe;
  logic [DATA_BITS-1:0] sample_in;
  logic                 sample_valid;
  logic                 sample_ready;

  modport slave (
    input  sclk, cs_n, sample_in, sample_valid,
    output sdata, sdata_oe, sample_ready
  );

  modport master (
    output sclk, cs_n, sample_in, sample_valid,
    input  sdata, sdata_oe, sample_ready
  );
endinterface

// File: rtl/adc_serial_emulator.sv
// Transmitter end of the camera serial ADC: answers one frame (leading zeros + sample, MSB first)
// per cs_n-low window, shifting on falling sclk. Sample from a holding register or a pattern generator.
module adc_serial_emulator #(
  parameter int                   DATA_BITS  = 12,
  parameter int                   LEAD_ZEROS = 4,
  parameter logic [DATA_BITS-1:0] LFSR_SEED  = 12'hACE
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  adc_serial_emulator_if.slave      bus,
  input  logic [1:0]                mode_i,
  output logic                      frame_done_o,
  output logic                      frame_abort_o,
  output logic                      underrun_o,
  output logic [15:0]               frame_count_o
);

  localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;
  localparam int CNT_W      = $clog2(FRAME_BITS);
  localparam logic [CNT_W-1:0]     LAST_BIT  = CNT_W'(FRAME_BITS - 1);
  localparam logic [DATA_BITS-1:0] CONST_PAT = DATA_BITS'(12'hA5A);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_TAIL
  } state_t;

  state_t                 state_q, state_d;
  logic                   sclk_q, cs_q;
  logic [FRAME_BITS-1:0]  shift_q, shift_d;
  logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]   hold_q, hold_d;
  logic                   hold_full_q, hold_full_d;
  logic [DATA_BITS-1:0]   last_q, last_d;
  logic [DATA_BITS-1:0]   ramp_q, ramp_d;
  logic [DATA_BITS-1:0]   lfsr_q, lfsr_d;
  logic                   done_q, done_d;
  logic                   abort_q, abort_d;
  logic                   under_q, under_d;
  logic [15:0]            count_q, count_d;

  logic                   cs_fall, cs_rise, sclk_fall;
  logic                   frame_start;
  logic [DATA_BITS-1:0]   sample_sel;
  logic                   lfsr_fb;

  assign cs_fall     = cs_q & ~bus.cs_n;
  assign cs_rise     = ~cs_q & bus.cs_n;
  assign sclk_fall   = sclk_q & ~bus.sclk;
  assign frame_start = cs_fall && (state_q == S_IDLE);

  // x^12 + x^6 + x^4 + x + 1, Fibonacci form shifting toward the MSB
  assign lfsr_fb = lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0];

  always_comb begin
    sample_sel = CONST_PAT;
    unique case (mode_i)
      2'b00:   sample_sel = hold_full_q ? hold_q : last_q;
      2'b01:   sample_sel = ramp_q;
      2'b10:   sample_sel = lfsr_q;
      default: sample_sel = CONST_PAT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bit_cnt_d   = bit_cnt_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    last_d      = last_q;
    ramp_d      = ramp_q;
    lfsr_d      = lfsr_q;
    done_d      = 1'b0;
    abort_d     = 1'b0;
    under_d     = 1'b0;
    count_d     = count_q;

    // A load in the consuming cycle wins: the frame takes the old value, the new one stays held.
    if (bus.sample_valid && !hold_full_q) begin
      hold_d      = bus.sample_in;
      hold_full_d = 1'b1;
    end else if (frame_start) begin
      hold_full_d = 1'b0;
    end

    unique case (state_q)
      S_IDLE: begin
        if (cs_fall) begin
          state_d   = S_SHIFT;
          shift_d   = {{LEAD_ZEROS{1'b0}}, sample_sel};
          bit_cnt_d = '0;
          last_d    = sample_sel;
          under_d   = (mode_i == 2'b00) && !hold_full_q;
          if (mode_i == 2'b01) ramp_d = ramp_q + 1'b1;
          if (mode_i == 2'b10) lfsr_d = {lfsr_q[DATA_BITS-2:0], lfsr_fb};
        end
      end
      S_SHIFT: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          abort_d = 1'b1;
        end else if (sclk_fall) begin
          shift_d = {shift_q[FRAME_BITS-2:0], 1'b0};
          if (bit_cnt_q == LAST_BIT) begin
            state_d = S_TAIL;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end
      end
      S_TAIL: begin
        if (cs_rise) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
          count_d = count_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      sclk_q      <= 1'b1;
      cs_q        <= 1'b1;
      shift_q     <= '0;
      bit_cnt_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      last_q      <= '0;
      ramp_q      <= '0;
      lfsr_q      <= LFSR_SEED;
      done_q      <= 1'b0;
      abort_q     <= 1'b0;
      under_q     <= 1'b0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      sclk_q      <= bus.sclk;
      cs_q        <= bus.cs_n;
      shift_q     <= shift_d;
      bit_cnt_q   <= bit_cnt_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      last_q      <= last_d;
      ramp_q      <= ramp_d;
      lfsr_q      <= lfsr_d;
      done_q      <= done_d;
      abort_q     <= abort_d;
      under_q     <= under_d;
      count_q     <= count_d;
    end
  end

  assign bus.sdata        = (state_q == S_SHIFT) & shift_q[FRAME_BITS-1];
  assign bus.sdata_oe     = (state_q != S_IDLE);
  assign bus.sample_ready = ~hold_full_q;
  assign frame_done_o     = done_q;
  assign frame_abort_o    = abort_q;
  assign underrun_o       = under_q;
  assign frame_count_o    = count_q;

endmodule
